data_mem_sync: RTL and testbench

- Parametrised successor to the team's single-pointer data memory.
- Single shared address for read and write, with:
  - generic data and address widths;
  - registered (1-cycle) reads with a valid strobe instead of a tristate output;
  - an automatic memory-clear sweep after synchronous reset;
  - a busy/error handshake.
- Sits between the core's load/store path and storage.

---
 rtl/data_mem_sync.sv | 100 ++++++++++
 tb/tb_data_mem_sync.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_sync.sv
// Single-port data memory with a shared address, registered reads, and an
// automatic post-reset clear sweep that reports requests made while it runs.
module data_mem_sync #(
    parameter int          DW       = 8,
    parameter int          AW       = 8,
    parameter logic [DW-1:0] INIT_VAL = '0
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic [AW-1:0] DataAddress,
    input  logic          ReadMem,
    input  logic          WriteMem,
    input  logic [DW-1:0] DataIn,
    output logic [DW-1:0] DataOut,
    output logic          RdValid,
    output logic          Busy,
    output logic          AccessErr
);

    localparam int DEPTH = 2 ** AW;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t        state;
    state_t        stateNext;
    logic [AW-1:0] clrAddr;
    logic [AW-1:0] clrAddrNext;
    logic [DW-1:0] core [DEPTH];

    logic          memWe;
    logic [AW-1:0] memWAddr;
    logic [DW-1:0] memWData;
    logic          rdAccept;
    logic          errNext;

    always_ff @(posedge CLK) begin
        state   <= stateNext;
        clrAddr <= clrAddrNext;
    end

    always_comb begin
        stateNext   = state;
        clrAddrNext = clrAddr;
        memWe       = 1'b0;
        memWAddr    = DataAddress;
        memWData    = DataIn;
        rdAccept    = 1'b0;
        errNext     = 1'b0;
        if (reset) begin
            // Requests on a reset edge vanish silently; no error is flagged.
            stateNext   = CLEAR;
            clrAddrNext = '0;
        end else begin
            unique case (state)
                CLEAR: begin
                    memWe       = 1'b1;
                    memWAddr    = clrAddr;
                    memWData    = INIT_VAL;
                    clrAddrNext = clrAddr + 1'b1;
                    errNext     = ReadMem | WriteMem;
                    if (clrAddr == '1) begin
                        stateNext = IDLE;
                    end
                end
                IDLE: begin
                    memWe    = WriteMem;
                    rdAccept = ReadMem;
                end
                default: stateNext = CLEAR;
            endcase
        end
    end

    assign Busy = (state == CLEAR);

    // Read-first on a same-address collision falls out of the NBA ordering.
    always_ff @(posedge CLK) begin
        if (memWe) begin
            core[memWAddr] <= memWData;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            DataOut   <= '0;
            RdValid   <= 1'b0;
            AccessErr <= 1'b0;
        end else begin
            RdValid   <= rdAccept;
            AccessErr <= errNext;
            if (rdAccept) begin
                DataOut <= core[DataAddress];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_sync.sv
// Directed bench for data_mem_sync: clear sweep, access during clear,
// table-driven read/write vectors, and reset in the middle of a sweep.
module tb_data_mem_sync;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam logic [7:0] INITV = 8'hA5;

    logic          CLK = 1'b0;
    logic          reset;
    logic [AW-1:0] DataAddress;
    logic          ReadMem;
    logic          WriteMem;
    logic [DW-1:0] DataIn;
    logic [DW-1:0] DataOut;
    logic          RdValid;
    logic          Busy;
    logic          AccessErr;

    int checks = 0;
    int errors = 0;

    data_mem_sync #(.DW(DW), .AW(AW), .INIT_VAL(INITV)) dut (
        .CLK(CLK),
        .reset(reset),
        .DataAddress(DataAddress),
        .ReadMem(ReadMem),
        .WriteMem(WriteMem),
        .DataIn(DataIn),
        .DataOut(DataOut),
        .RdValid(RdValid),
        .Busy(Busy),
        .AccessErr(AccessErr)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       rd;
        logic       wr;
        logic [3:0] addr;
        logic [7:0] din;
        logic [7:0] expDout;
        logic       expRv;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idleIn();
        ReadMem     = 1'b0;
        WriteMem    = 1'b0;
        DataAddress = '0;
        DataIn      = '0;
    endtask

    task automatic waitSweep(input string name);
        int cnt;
        cnt = 0;
        while (Busy === 1'b1 && cnt < 40) begin
            step();
            cnt++;
        end
        chk(name, cnt, 16);
    endtask

    initial begin
        int cnt;
        vecs[0]  = '{1'b0, 1'b1, 4'd7, 8'd200, 8'hA5,  1'b0};
        vecs[1]  = '{1'b1, 1'b0, 4'd7, 8'd0,   8'd200, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 4'd0, 8'd0,   8'd200, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 4'd0, 8'd0,   8'd200, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 4'd3, 8'd11,  8'd200, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 4'd3, 8'd99,  8'd11,  1'b1};
        vecs[6]  = '{1'b1, 1'b0, 4'd3, 8'd0,   8'd99,  1'b1};
        vecs[7]  = '{1'b0, 1'b1, 4'd0, 8'd1,   8'd99,  1'b0};
        vecs[8]  = '{1'b0, 1'b1, 4'd1, 8'd2,   8'd99,  1'b0};
        vecs[9]  = '{1'b0, 1'b1, 4'd2, 8'd3,   8'd99,  1'b0};
        vecs[10] = '{1'b1, 1'b0, 4'd0, 8'd0,   8'd1,   1'b1};
        vecs[11] = '{1'b1, 1'b0, 4'd1, 8'd0,   8'd2,   1'b1};
        vecs[12] = '{1'b1, 1'b0, 4'd2, 8'd0,   8'd3,   1'b1};
        vecs[13] = '{1'b0, 1'b0, 4'd0, 8'd0,   8'd3,   1'b0};

        // Reset held two cycles
        reset = 1'b1;
        idleIn();
        step();
        step();
        chk("rst_busy", Busy, 1);
        chk("rst_dout", DataOut, 0);
        chk("rst_rdvalid", RdValid, 0);
        chk("rst_accesserr", AccessErr, 0);

        // Sweep with a write attempted while busy
        reset = 1'b0;
        cnt = 0;
        while (Busy === 1'b1 && cnt < 40) begin
            if (cnt == 5) begin
                WriteMem    = 1'b1;
                DataAddress = 4'd2;
                DataIn      = 8'd55;
            end
            step();
            cnt++;
            if (cnt == 6) begin
                chk("busy_err_pulse", AccessErr, 1);
                chk("busy_err_rdvalid", RdValid, 0);
                chk("busy_err_dout", DataOut, 0);
                idleIn();
            end
            if (cnt == 7) chk("busy_err_drop", AccessErr, 0);
        end
        chk("sweep_len", cnt, 16);
        chk("sweep_busy_low", Busy, 0);

        for (int a = 0; a < 16; a++) begin
            ReadMem     = 1'b1;
            DataAddress = 4'(a);
            step();
            chk($sformatf("clr_rd%0d", a), DataOut, INITV);
            chk($sformatf("clr_rv%0d", a), RdValid, 1);
        end
        idleIn();
        step();
        chk("clr_rv_drop", RdValid, 0);
        chk("clr_hold", DataOut, INITV);

        for (int i = 0; i < 14; i++) begin
            ReadMem     = vecs[i].rd;
            WriteMem    = vecs[i].wr;
            DataAddress = vecs[i].addr;
            DataIn      = vecs[i].din;
            step();
            chk($sformatf("vec%0d_dout", i), DataOut, vecs[i].expDout);
            chk($sformatf("vec%0d_rv", i), RdValid, vecs[i].expRv);
            chk($sformatf("vec%0d_err", i), AccessErr, 0);
        end
        idleIn();

        // Reset mid-sweep, with a read on the reset edge
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 9; k++) step();
        chk("mid_busy", Busy, 1);
        reset   = 1'b1;
        ReadMem = 1'b1;
        DataAddress = 4'd7;
        step();
        chk("mid_rst_err", AccessErr, 0);
        chk("mid_rst_rv", RdValid, 0);
        chk("mid_rst_dout", DataOut, 0);
        reset = 1'b0;
        idleIn();
        waitSweep("mid_sweep_len");

        ReadMem = 1'b1;
        DataAddress = 4'd7;
        step();
        chk("mid_rd7", DataOut, INITV);
        DataAddress = 4'd3;
        step();
        chk("mid_rd3", DataOut, INITV);
        DataAddress = 4'd1;
        step();
        chk("mid_rd1", DataOut, INITV);
        chk("mid_rv", RdValid, 1);
        idleIn();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
